// File: rtl/mrf_nwnr_byp_pkg.sv
// Shared configuration for the multi-ported register file: default GPR geometry
// and the clear-sweep state encoding.
package mrf_nwnr_byp_pkg;
    localparam int MRF_DW = 64;
    localparam int MRF_AW = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } mrf_state_e;
endpackage

// File: rtl/mrf_wsel.sv
// Combinational priority select over the write ports: for a probe address,
// reports whether any enabled writer targets it and the highest-index writer's data.
module mrf_wsel #(
    parameter int DW = 64,
    parameter int AW = 5,
    parameter int NW = 2
) (
    input  logic [AW-1:0]    addr,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    output logic             hit,
    output logic [DW-1:0]    data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so the highest-index matching port overrides the rest.
        for (int j = 0; j < NW; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wdata[j*DW +: DW];
            end
        end
    end
endmodule

// File: rtl/mrf_nwnr_byp.sv
// NW-write / NR-read register file with registered reads, optional same-cycle
// write-to-read bypass and an optional zeroing sweep after reset.
module mrf_nwnr_byp
    import mrf_nwnr_byp_pkg::*;
#(
    parameter int DW         = MRF_DW,
    parameter int AW         = MRF_AW,
    parameter int NR         = 2,
    parameter int NW         = 2,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             BUSY,
    input  logic [NR-1:0]    RE,
    input  logic [NR*AW-1:0] RADDR,
    output logic [NR*DW-1:0] RDATA,
    input  logic [NW-1:0]    WE,
    input  logic [NW*AW-1:0] WADDR,
    input  logic [NW*DW-1:0] WDATA
);
    localparam int DEPTH = 1 << AW;

    mrf_state_e    state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic          sweeping;
    logic [NW-1:0] port_we;

    logic [DW-1:0] mem      [DEPTH];
    logic [DEPTH-1:0] ent_hit;
    logic [DW-1:0] ent_data [DEPTH];
    logic [NR-1:0] byp_hit;
    logic [DW-1:0] byp_data [NR];
    logic [DW-1:0] rd_q     [NR];

    assign sweeping = (state == ST_CLEAR);
    assign BUSY     = sweeping && !RST;
    // Port writes are dropped while in reset or sweeping; bypass sees the same gating.
    assign port_we  = (RST || sweeping) ? '0 : WE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1))
                    state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        mrf_wsel #(.DW(DW), .AW(AW), .NW(NW)) u_wsel (
            .addr  (AW'(e)),
            .we    (port_we),
            .waddr (WADDR),
            .wdata (WDATA),
            .hit   (ent_hit[e]),
            .data  (ent_data[e])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (sweeping) begin
                mem[ptr] <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++)
                    if (ent_hit[e])
                        mem[e] <= ent_data[e];
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        mrf_wsel #(.DW(DW), .AW(AW), .NW(NW)) u_byp (
            .addr  (RADDR[i*AW +: AW]),
            .we    (port_we),
            .waddr (WADDR),
            .wdata (WDATA),
            .hit   (byp_hit[i]),
            .data  (byp_data[i])
        );
        assign RDATA[i*DW +: DW] = rd_q[i];
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NR; i++) begin
            if (RST || sweeping)
                rd_q[i] <= '0;
            else if (RE[i])
                rd_q[i] <= ((BYPASS != 0) && byp_hit[i]) ? byp_data[i]
                                                         : mem[RADDR[i*AW +: AW]];
        end
    end
endmodule

// File: tb/tb_mrf_nwnr_byp.sv
// Random and directed bench for mrf_nwnr_byp; a bypass and a no-bypass instance
// share stimulus and are checked against an array-based reference model.
module tb_mrf_nwnr_byp;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 1 << AW;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NR-1:0]    RE;
    logic [NR*AW-1:0] RADDR;
    logic [NW-1:0]    WE;
    logic [NW*AW-1:0] WADDR;
    logic [NW*DW-1:0] WDATA;
    logic [NR*DW-1:0] rdata1, rdata0;
    logic             busy1, busy0;

    int nvec = 0;
    int nmis = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp1  [NR];
    logic [DW-1:0] exp0  [NR];
    int            m_left;

    always #5 CLK = ~CLK;

    mrf_nwnr_byp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .BYPASS(1), .CLR_ON_RST(1)) u_b1 (
        .CLK(CLK), .RST(RST), .BUSY(busy1), .RE(RE), .RADDR(RADDR), .RDATA(rdata1),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA)
    );

    mrf_nwnr_byp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .BYPASS(0), .CLR_ON_RST(1)) u_b0 (
        .CLK(CLK), .RST(RST), .BUSY(busy0), .RE(RE), .RADDR(RADDR), .RDATA(rdata0),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RE = '0; WE = '0; RADDR = '0; WADDR = '0; WDATA = '0;
    endtask

    task automatic wr(input int j, input int a, input logic [DW-1:0] d);
        WE[j] = 1'b1;
        WADDR[j*AW +: AW] = AW'(a);
        WDATA[j*DW +: DW] = d;
    endtask

    task automatic rd(input int i, input int a);
        RE[i] = 1'b1;
        RADDR[i*AW +: AW] = AW'(a);
    endtask

    // One clock: check BUSY on current inputs, advance the model, clock, check RDATA.
    task automatic step();
        logic          eb;
        logic [AW-1:0] ra;
        logic [DW-1:0] old, fwd;
        #1;
        eb = !RST && (m_left > 0);
        chk("busy_b1", {63'b0, busy1}, {63'b0, eb});
        chk("busy_b0", {63'b0, busy0}, {63'b0, eb});
        if (RST) begin
            for (int i = 0; i < NR; i++) begin exp1[i] = '0; exp0[i] = '0; end
            m_left = DEPTH;
        end else if (m_left > 0) begin
            for (int i = 0; i < NR; i++) begin exp1[i] = '0; exp0[i] = '0; end
            mem_m[DEPTH - m_left] = '0;
            m_left--;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (RE[i]) begin
                    ra  = RADDR[i*AW +: AW];
                    old = mem_m[ra];
                    fwd = old;
                    for (int j = 0; j < NW; j++)
                        if (WE[j] && WADDR[j*AW +: AW] == ra) fwd = WDATA[j*DW +: DW];
                    exp1[i] = fwd;
                    exp0[i] = old;
                end
            end
            for (int j = 0; j < NW; j++)
                if (WE[j]) mem_m[WADDR[j*AW +: AW]] = WDATA[j*DW +: DW];
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("rd_b1[%0d]", i), rdata1[i*DW +: DW], exp1[i]);
            chk($sformatf("rd_b0[%0d]", i), rdata0[i*DW +: DW], exp0[i]);
        end
    endtask

    task automatic rnd_writes();
        WE = NW'($urandom);
        for (int j = 0; j < NW; j++) begin
            WADDR[j*AW +: AW] = AW'($urandom);
            WDATA[j*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    initial begin
        int n;
        logic [DW-1:0] held;
        m_left = 0;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        for (int i = 0; i < NR; i++) begin exp1[i] = '0; exp0[i] = '0; end
        idle();
        RST = 1'b1;
        repeat (3) step();

        // Sweep, interrupted by a one-cycle reset at sweep cycle 10.
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin rnd_writes(); RE = '1; step(); end
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        n = 0;
        while (busy1 && n < 100) begin
            rnd_writes();
            RE = '1;
            step();
            n++;
        end
        chk("busy_len", DW'(n), DW'(DEPTH));
        idle();

        for (int a = 0; a < DEPTH; a++) begin
            idle();
            rd(0, a);
            rd(1, DEPTH - 1 - a);
            step();
            chk("clr_rd", rdata1[DW-1:0], '0);
        end

        // Basic write then read on the other port, then hold.
        idle(); wr(0, 3, 64'h1111_2222_3333_4444); step();
        idle(); rd(1, 3); step();
        chk("basic_rd", rdata1[DW +: DW], 64'h1111_2222_3333_4444);
        held = rdata1[DW +: DW];
        for (int c = 0; c < 5; c++) begin
            idle(); rd(0, c); RADDR[AW +: AW] = AW'(c + 10); wr(1, 3, 64'hdead); step();
        end
        chk("hold_rd", rdata1[DW +: DW], held);

        // Same-address collision: higher port wins.
        idle(); wr(0, 7, 64'hA); wr(1, 7, 64'hB); step();
        idle(); rd(0, 7); step();
        chk("collide", rdata1[DW-1:0], 64'hB);

        // Bypass vs read-before-write.
        idle(); wr(1, 9, 64'h5); step();
        idle(); wr(0, 9, 64'h6); rd(0, 9); step();
        chk("byp_on", rdata1[DW-1:0], 64'h6);
        chk("byp_off", rdata0[DW-1:0], 64'h5);
        idle(); rd(0, 9); step();
        chk("byp_off_nxt", rdata0[DW-1:0], 64'h6);

        // Random regression; narrow address window half the time to force collisions.
        for (int c = 0; c < 10000; c++) begin
            logic narrow;
            narrow = $urandom_range(0, 1) == 1;
            RST = ($urandom_range(0, 999) == 0);
            RE  = NR'($urandom);
            WE  = NW'($urandom);
            for (int i = 0; i < NR; i++)
                RADDR[i*AW +: AW] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
            for (int j = 0; j < NW; j++) begin
                WADDR[j*AW +: AW] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
                WDATA[j*DW +: DW] = {$urandom, $urandom};
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
